// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - parametrised load/store data memory with valid/ready handshake
//
// Single-ported data memory for the core's load/store path. Accepts one request
// at a time, writes stores at the acceptance edge, captures load data at the
// acceptance edge and presents the response RD_LAT cycles later.
//
// Parameters: DATA_W (32|64), DEPTH (words), ADDR_W (byte address bits), RD_LAT (1..4)
// Ports:
//   clk, rstd                 clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake
//   req_we, req_size          store/load, size 0=byte 1=half 2=word32 3=dword64
//   req_signed                sign-extend narrow loads
//   req_addr, req_wdata       byte address, right-justified store data
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata, rsp_err        extended load data (0 for stores/errors), error flag
// Build option: DMEM_MISALIGN_TRAP_EN - misaligned accesses report an error;
//   when undefined the address is aligned down and the access proceeds.
module data_mem_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [OFF_W-1:0]  off_raw, off_eff, align_mask;
    int                nbytes;
    logic              range_err, size_err, align_err, req_err;
    logic [NB-1:0]     lane_en;
    logic [DATA_W-1:0] wdata_sh, rd_sh, load_val;
    logic              sign_bit;

    // Address decode, error checks, lane selection and load formatting
    always_comb begin
        accept     = req_valid && req_ready_q && rstd;
        word_idx   = req_addr[ADDR_W-1:OFF_W];
        mem_idx    = word_idx[MEM_AW-1:0];
        off_raw    = req_addr[OFF_W-1:0];
        align_mask = OFF_W'((1 << req_size) - 1);
        nbytes     = 1 << req_size;
        range_err  = 32'(word_idx) >= 32'(DEPTH);
        size_err   = (req_size == 2'd3) && (DATA_W == 32);
        align_err  = TRAP_EN && ((off_raw & align_mask) != '0);
        req_err    = range_err || size_err || align_err;
        // With trapping the masked bits are already zero on legal requests,
        // so aligning down is harmless in both builds.
        off_eff    = off_raw & ~align_mask;
        for (int i = 0; i < NB; i++) begin
            lane_en[i] = (i >= int'(off_eff)) && (i < int'(off_eff) + nbytes);
        end
        wdata_sh = req_wdata << (8 * int'(off_eff));
        rd_sh    = mem[mem_idx] >> (8 * int'(off_eff));
        case (req_size)
            2'd0:    sign_bit = rd_sh[7];
            2'd1:    sign_bit = rd_sh[15];
            default: sign_bit = rd_sh[31];
        endcase
        for (int b = 0; b < DATA_W; b++) begin
            if (b < 8 * nbytes) begin
                load_val[b] = rd_sh[b];
            end else begin
                load_val[b] = req_signed & sign_bit;
            end
        end
    end

    // Request/response sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_err_d   = req_err;
                    rsp_rdata_d = (req_err || req_we) ? '0 : load_val;
                    if (RD_LAT == 1) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(RD_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not reset; a store accepted before a reset stays written
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (accept && req_we && !req_err && lane_en[i]) begin
                mem[mem_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - scoreboard bench for data_mem_unit (32-bit/RD_LAT=1 and 64-bit/RD_LAT=3)
module tb_data_mem_unit;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstd;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we, a_req_signed;
    logic [1:0]  a_req_size;
    logic [10:0] a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_signed;
    logic [1:0]  b_req_size;
    logic [10:0] b_req_addr;
    logic [63:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;

    data_mem_unit #(.DATA_W(32), .DEPTH(256), .ADDR_W(11), .RD_LAT(1)) u_a (
        .clk(clk), .rstd(rstd),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_unit #(.DATA_W(64), .DEPTH(256), .ADDR_W(11), .RD_LAT(3)) u_b (
        .clk(clk), .rstd(rstd),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic [63:0] d;
        logic        e;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop expected response on every response handshake
    always @(negedge clk) begin
        if (rstd && a_rsp_valid && a_rsp_ready) begin
            if (q_a.size() == 0) begin
                chk("a unexpected response", 64'(a_rsp_valid), 64'd0);
            end else begin
                ea = q_a.pop_front();
                chk({ea.name, " rdata"}, 64'(a_rsp_rdata), ea.d);
                chk({ea.name, " err"}, 64'(a_rsp_err), 64'(ea.e));
            end
        end
    end

    always @(negedge clk) begin
        if (rstd && b_rsp_valid && b_rsp_ready) begin
            if (q_b.size() == 0) begin
                chk("b unexpected response", 64'(b_rsp_valid), 64'd0);
            end else begin
                eb = q_b.pop_front();
                chk({eb.name, " rdata"}, b_rsp_rdata, eb.d);
                chk({eb.name, " err"}, 64'(b_rsp_err), 64'(eb.e));
            end
        end
    end

    function automatic logic rv(input int u);
        return (u == 0) ? a_rsp_valid : b_rsp_valid;
    endfunction
    function automatic logic rr(input int u);
        return (u == 0) ? a_req_ready : b_req_ready;
    endfunction
    function automatic logic [63:0] rd(input int u);
        return (u == 0) ? 64'(a_rsp_rdata) : b_rsp_rdata;
    endfunction
    function automatic logic re(input int u);
        return (u == 0) ? a_rsp_err : b_rsp_err;
    endfunction

    task automatic drive(input int u, input logic v, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [10:0] ad, input logic [63:0] wd);
        if (u == 0) begin
            a_req_valid = v; a_req_we = we; a_req_size = sz; a_req_signed = sg;
            a_req_addr = ad; a_req_wdata = wd[31:0];
        end else begin
            b_req_valid = v; b_req_we = we; b_req_size = sz; b_req_signed = sg;
            b_req_addr = ad; b_req_wdata = wd;
        end
    endtask

    task automatic set_rr(input int u, input logic v);
        if (u == 0) a_rsp_ready = v;
        else        b_rsp_ready = v;
    endtask

    // Issue one request (called at posedge+1), push expectation, check timing
    task automatic do_req(input string name, input int u, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [10:0] ad, input logic [63:0] wd,
                          input logic [63:0] exp_d, input logic exp_e, input int hold);
        int          lat;
        logic [63:0] d0;
        logic        e0;
        exp_t        x;
        x.d = exp_d; x.e = exp_e; x.name = name;
        if (u == 0) q_a.push_back(x);
        else        q_b.push_back(x);
        drive(u, 1'b1, we, sz, sg, ad, wd);
        @(posedge clk); #1;
        lat = 1;
        // Inputs change after acceptance; the pending response must not follow
        drive(u, 1'b0, ~we, ~sz, ~sg, ~ad, ~wd);
        chk({name, " req_ready after accept"}, 64'(rr(u)), 64'd0);
        while (!rv(u) && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), (u == 0) ? 64'd1 : 64'd3);
        d0 = rd(u);
        e0 = re(u);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " held valid"}, 64'(rv(u)), 64'd1);
            chk({name, " held rdata"}, rd(u), d0);
            chk({name, " held err"}, 64'(re(u)), 64'(e0));
            chk({name, " held req_ready"}, 64'(rr(u)), 64'd0);
        end
        set_rr(u, 1'b1);
        @(posedge clk); #1;
        set_rr(u, 1'b0);
        chk({name, " req_ready after handshake"}, 64'(rr(u)), 64'd1);
        chk({name, " rsp_valid after handshake"}, 64'(rv(u)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstd = 1'b0;
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 11'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 11'd0, 64'd0);
        set_rr(0, 1'b0);
        set_rr(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("a reset req_ready", 64'(a_req_ready), 64'd1);
        chk("a reset rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("a reset rsp_rdata", 64'(a_rsp_rdata), 64'd0);
        chk("a reset rsp_err", 64'(a_rsp_err), 64'd0);
        chk("b reset req_ready", 64'(b_req_ready), 64'd1);
        chk("b reset rsp_valid", 64'(b_rsp_valid), 64'd0);
        chk("b reset rsp_rdata", b_rsp_rdata, 64'd0);
        chk("b reset rsp_err", 64'(b_rsp_err), 64'd0);
        @(negedge clk);
        rstd = 1'b1;
        @(posedge clk); #1;

        // 32-bit unit, RD_LAT=1
        do_req("a st w 0x10", 0, 1, 2'd2, 0, 11'h010, 64'h12345678, 64'h0, 0, 0);
        do_req("a st w 0x00", 0, 1, 2'd2, 0, 11'h000, 64'h11111111, 64'h0, 0, 0);
        do_req("a ld w 0x10", 0, 0, 2'd2, 0, 11'h010, 64'h0, 64'h12345678, 0, 2);
        do_req("a st b 0x11", 0, 1, 2'd0, 0, 11'h011, 64'h777777AB, 64'h0, 0, 0);
        do_req("a ld sb 0x11", 0, 0, 2'd0, 1, 11'h011, 64'h0, 64'hFFFFFFAB, 0, 0);
        do_req("a ld ub 0x11", 0, 0, 2'd0, 0, 11'h011, 64'h0, 64'h000000AB, 0, 0);
        do_req("a ld w 0x10 after byte", 0, 0, 2'd2, 0, 11'h010, 64'h0, 64'h1234AB78, 0, 0);
        do_req("a ld sh 0x10", 0, 0, 2'd1, 1, 11'h010, 64'h0, 64'hFFFFAB78, 0, 0);
        do_req("a ld h 0x13 misaligned", 0, 0, 2'd1, 0, 11'h013, 64'h0,
               TRAP ? 64'h0 : 64'h00001234, TRAP, 1);
        do_req("a ld w 0x10 after misaligned load", 0, 0, 2'd2, 0, 11'h010, 64'h0, 64'h1234AB78, 0, 0);
        do_req("a st h 0x13 misaligned", 0, 1, 2'd1, 0, 11'h013, 64'h5A5A, 64'h0, TRAP, 0);
        do_req("a ld w 0x10 after misaligned store", 0, 0, 2'd2, 0, 11'h010, 64'h0,
               TRAP ? 64'h1234AB78 : 64'h5A5AAB78, 0, 0);
        do_req("a ld w 0x400 range", 0, 0, 2'd2, 0, 11'h400, 64'h0, 64'h0, 1, 0);
        do_req("a st w 0x400 range", 0, 1, 2'd2, 0, 11'h400, 64'hDEADBEEF, 64'h0, 1, 0);
        do_req("a ld w 0x00 untouched", 0, 0, 2'd2, 0, 11'h000, 64'h0, 64'h11111111, 0, 0);
        do_req("a ld size3 illegal", 0, 0, 2'd3, 0, 11'h010, 64'h0, 64'h0, 1, 0);
        do_req("a st h 0x12", 0, 1, 2'd1, 0, 11'h012, 64'hBEEF, 64'h0, 0, 0);
        do_req("a ld w 0x10 after half", 0, 0, 2'd2, 0, 11'h010, 64'h0, 64'hBEEFAB78, 0, 0);
        do_req("a ld uh 0x12", 0, 0, 2'd1, 0, 11'h012, 64'h0, 64'h0000BEEF, 0, 0);
        do_req("a ld sh 0x12", 0, 0, 2'd1, 1, 11'h012, 64'h0, 64'hFFFFBEEF, 0, 0);

        // 64-bit unit, RD_LAT=3
        set_rr(1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("b idle rsp_ready ignored valid", 64'(b_rsp_valid), 64'd0);
        chk("b idle rsp_ready ignored ready", 64'(b_req_ready), 64'd1);
        set_rr(1, 1'b0);
        do_req("b st d 0x8", 1, 1, 2'd3, 0, 11'h008, 64'h0123456789ABCDEF, 64'h0, 0, 0);
        do_req("b ld d 0x8 stalled", 1, 0, 2'd3, 1, 11'h008, 64'h0, 64'h0123456789ABCDEF, 0, 5);
        do_req("b ld sw 0xC", 1, 0, 2'd2, 1, 11'h00C, 64'h0, 64'h0000000001234567, 0, 0);
        do_req("b ld sw 0x8", 1, 0, 2'd2, 1, 11'h008, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 0);
        do_req("b ld ub 0xF", 1, 0, 2'd0, 0, 11'h00F, 64'h0, 64'h0000000000000001, 0, 0);
        do_req("b ld sh 0xA", 1, 0, 2'd1, 1, 11'h00A, 64'h0, 64'hFFFFFFFFFFFF89AB, 0, 0);
        do_req("b ld w 0xA misaligned", 1, 0, 2'd2, 0, 11'h00A, 64'h0,
               TRAP ? 64'h0 : 64'h0000000089ABCDEF, TRAP, 0);

        // Reset while a store waits for its response
        drive(1, 1'b1, 1'b1, 2'd2, 1'b0, 11'h010, 64'hFFFFFFFFCAFEF00D);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 11'h000, 64'h0);
        chk("b store in WAIT req_ready", 64'(b_req_ready), 64'd0);
        rstd = 1'b0;
        #1;
        chk("b reset mid-op rsp_valid", 64'(b_rsp_valid), 64'd0);
        chk("b reset mid-op req_ready", 64'(b_req_ready), 64'd1);
        @(negedge clk);
        rstd = 1'b1;
        @(posedge clk); #1;
        do_req("b ld w 0x10 after reset", 1, 0, 2'd2, 0, 11'h010, 64'h0, 64'h00000000CAFEF00D, 0, 0);

        for (int i = 0; i < 10 && (q_a.size() + q_b.size()) != 0; i++) begin
            @(posedge clk);
        end
        chk("scoreboard drained", 64'(q_a.size() + q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory unit for the single-cycle core's load/store path. It replaces the four fixed byte-lane 256×8 memories with one block of configurable width, depth and read latency. Requests use a valid/ready handshake, with byte, half and word accesses, sign/zero extension of loads, and alignment/range checking. It sits between the execute stage's address/ALU result and the writeback mux, and gives the core a memory that can stall.

## Interface
- DATA_W, 32, word width in bits; 32 or 64 only
- DEPTH, 256, number of words
- ADDR_W, 10, byte-address width; must satisfy 2^ADDR_W ≥ DEPTH·DATA_W/8
- RD_LAT, 1, cycles from request acceptance to response; 1..4
- clk  in  1  clock, rising edge
- rstd  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word32, 3 dword64 (legal only when DATA_W=64)
- req_signed  in  1  sign-extend the load result (ignored for stores and full-width loads)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified (bits [8·size_bytes−1:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_W  load data, right-justified and extended; 0 for stores and errors
- rsp_err  out  1  request was rejected (misaligned, out of range or illegal size)

## Operation
- Lanes are little-endian. NB = DATA_W/8 byte lanes. The word index is req_addr >> log2(NB). The byte offset is req_addr[log2(NB)−1:0].
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted and the FSM goes to WAIT.
  - WAIT: counter counts RD_LAT−1 down to 0, then the FSM goes to RESP. If RD_LAT=1, the FSM goes straight to RESP.
  - RESP: rsp_valid=1. On rsp_ready, the FSM goes to IDLE.
- Only one request is outstanding at a time. req_ready is 0 in WAIT and RESP.
- Store acceptance writes the selected byte lanes at the acceptance edge:
  - byte: lane = offset
  - half: lanes offset, offset+1
  - word32: 4 lanes from the offset
  - dword: all lanes
  - Store data is shifted to lane position. Unselected lanes are unchanged.
- Load data is captured from the word at acceptance. It is shifted down by offset, masked to the access size, and then sign-extended (req_signed=1) or zero-extended.
- Error conditions (see Configuration for misalignment):
  - word index ≥ DEPTH
  - size 3 with DATA_W=32
  - misaligned access: offset not a multiple of the access size
- On error: no memory write, rsp_err=1, rsp_rdata=0. The response timing is the same as for a legal request.
- Memory contents are not cleared by reset.

## Timing
- Reset values: FSM in IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- rsp_valid rises exactly RD_LAT cycles after the acceptance edge.
- rsp_rdata and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- After the response handshake, req_ready is 1 in the next cycle. Minimum spacing is RD_LAT+1 cycles per request.
- Read-after-write: a load accepted in any cycle after a store's acceptance sees the stored data.
- Reset asserted mid-operation: the pending response is discarded and the FSM returns to IDLE immediately. A store that was already accepted stays written.
- req_* inputs are sampled only at the acceptance edge. Changes in WAIT or RESP have no effect.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a misaligned access is an error, as described above.
- DMEM_MISALIGN_TRAP_EN undefined: the offset bits below the access size are forced to 0 (the address is aligned down) and the access proceeds with no error. Range and size errors are still reported.

## Test plan
- DATA_W=32, RD_LAT=1: store word 0x12345678 to addr 0x10, then load word from 0x10 -> rsp_valid 1 cycle after acceptance, rdata 0x12345678, err 0.
- After the above, store byte 0xAB to 0x11, then load signed byte from 0x11 and unsigned byte from 0x11 -> 0xFFFFFFAB and 0x000000AB. Load word from 0x10 -> 0x1234AB78.
- RD_LAT=3, rsp_ready held low 5 cycles -> rsp_valid high from cycle 3, data held stable, req_ready 0 until the cycle after the rsp_ready handshake.
- Trap enabled: load half from 0x13 -> err 1, rdata 0, memory unchanged. Trap disabled: same request -> reads the half at 0x12, err 0.
- DEPTH=256, DATA_W=32: access to 0x400 with ADDR_W=11 -> err 1. Size 3 with DATA_W=32 -> err 1. DATA_W=64: dword store then load of 0x0123456789ABCDEF at 0x8 -> round-trips.
- Assert rstd low during WAIT of a store -> rsp_valid 0 and req_ready 1 immediately. A subsequent load of that address returns the stored value.
